// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA drawing path.
package vga_pkg;
  localparam int X_MAX    = 160;
  localparam int Y_MAX    = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_DRAW  = 2'd1;
  localparam state_t S_CLEAR = 2'd2;
  localparam state_t S_DONE  = 2'd3;
endpackage

// File: rtl/box_plotter_if.sv
// Command/pixel bundle between the control FSM (master) and box_plotter (slave).
interface box_plotter_if;
  import vga_pkg::*;

  logic                start;
  logic                clear;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [COLOUR_W-1:0] colour_in;
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                plot;
  logic                busy;
  logic                done;

  modport master (
    output start, clear, x_in, y_in, colour_in,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  modport slave (
    input  start, clear, x_in, y_in, colour_in,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/raster_counter.sv
// Column/row raster counter with runtime limits; last flags the final (col,row).
module raster_counter #(
  parameter int COL_W = 8,
  parameter int ROW_W = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [COL_W-1:0] col_last,
  input  logic [ROW_W-1:0] row_last,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_wrap;
  logic             w_row_wrap;

  assign w_col_wrap = (r_col == col_last);
  assign w_row_wrap = (r_row == row_last);
  assign last       = w_col_wrap & w_row_wrap;
  assign col        = r_col;
  assign row        = r_row;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/box_plotter.sv
// Square/clear drawing engine: one registered pixel per clock toward vga_adapter.
//   state   | meaning
//   S_IDLE  | waiting for start/clear; counter held at (0,0)
//   S_DRAW  | streaming the SIZE x SIZE square
//   S_CLEAR | streaming the full screen in black
//   S_DONE  | one-cycle done pulse, then back to idle
module box_plotter
  import vga_pkg::*;
#(
  parameter int SIZE = 4
) (
  input logic          clock,
  input logic          reset,
  box_plotter_if.slave bus
);
  state_t              r_state;
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_fin;
  logic [X_W-1:0]      r_x_out;
  logic [Y_W-1:0]      r_y_out;
  logic [COLOUR_W-1:0] r_colour_out;
  logic                r_plot;
  logic                r_busy;
  logic                r_done;

  logic                w_idle;
  logic                w_accept;
  logic                w_clr_mode;
  logic                w_emit;
  logic                w_cnt_clr;
  logic [X_W-1:0]      w_col_last;
  logic [Y_W-1:0]      w_row_last;
  logic [X_W-1:0]      w_col;
  logic [Y_W-1:0]      w_row;
  logic                w_last;
  logic [X_W-1:0]      w_x_base;
  logic [Y_W-1:0]      w_y_base;
  logic [X_W:0]        w_x_sum;
  logic [Y_W:0]        w_y_sum;
  logic                w_on_screen;
  logic [COLOUR_W-1:0] w_colour;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && (bus.start || bus.clear);

  // In idle the incoming command picks the limits so pixel 0 can leave on the accept edge.
  assign w_clr_mode = w_idle ? bus.clear : (r_state == S_CLEAR);
  assign w_col_last = w_clr_mode ? X_W'(X_MAX - 1) : X_W'(SIZE - 1);
  assign w_row_last = w_clr_mode ? Y_W'(Y_MAX - 1) : Y_W'(SIZE - 1);

  // r_fin marks that the final pixel is already on the outputs.
  assign w_emit    = w_accept || (((r_state == S_DRAW) || (r_state == S_CLEAR)) && !r_fin);
  assign w_cnt_clr = (r_state == S_DONE) || (w_idle && !w_accept);

  raster_counter #(.COL_W(X_W), .ROW_W(Y_W)) u_raster (
    .clock    (clock),
    .reset    (reset),
    .clr      (w_cnt_clr),
    .en       (w_emit),
    .col_last (w_col_last),
    .row_last (w_row_last),
    .col      (w_col),
    .row      (w_row),
    .last     (w_last)
  );

  assign w_x_base    = w_clr_mode ? '0 : (w_idle ? bus.x_in : r_x0);
  assign w_y_base    = w_clr_mode ? '0 : (w_idle ? bus.y_in : r_y0);
  assign w_x_sum     = {1'b0, w_x_base} + {1'b0, w_col};
  assign w_y_sum     = {1'b0, w_y_base} + {1'b0, w_row};
  assign w_on_screen = (w_x_sum < (X_W+1)'(X_MAX)) && (w_y_sum < (Y_W+1)'(Y_MAX));
  assign w_colour    = w_clr_mode ? BLACK : (w_idle ? bus.colour_in : r_colour);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_x0         <= '0;
      r_y0         <= '0;
      r_colour     <= '0;
      r_fin        <= 1'b0;
      r_x_out      <= '0;
      r_y_out      <= '0;
      r_colour_out <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_emit) begin
        r_x_out      <= w_x_sum[X_W-1:0];
        r_y_out      <= w_y_sum[Y_W-1:0];
        r_colour_out <= w_colour;
        r_plot       <= w_clr_mode | w_on_screen;
        r_busy       <= 1'b1;
        r_fin        <= w_last;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x0     <= bus.x_in;
            r_y0     <= bus.y_in;
            r_colour <= bus.colour_in;
            r_state  <= bus.clear ? S_CLEAR : S_DRAW;
          end
        end
        S_DRAW, S_CLEAR: begin
          if (r_fin) begin
            r_state <= S_DONE;
            r_fin   <= 1'b0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour_out = r_colour_out;
  assign bus.plot       = r_plot;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
